// File: rtl/reg1.sv
// Pipeline stage register / delay line: carries a reg_size-bit word through STAGES flops.
// Latency: STAGES clock cycles; serial_output is driven straight from the last flop.
// Backpressure: none; every rising edge with reset high advances the pipe unconditionally.
module reg1 #(
    parameter int                   reg_size    = 12,
    parameter int                   STAGES      = 1,
    parameter logic [reg_size-1:0]  RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [reg_size-1:0] serial_input,
    output logic [reg_size-1:0] serial_output
);

    if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
        $error("reg1: STAGES must be in the range 1..16");
    end

    logic [reg_size-1:0] stage_q [STAGES];
    logic [reg_size-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = serial_input;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset is asynchronous, so an edge coinciding with reset assertion cannot leak data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign serial_output = stage_q[STAGES-1];

endmodule

// File: tb/tb_reg1.sv
// Bench for reg1: single-stage and three-stage instances driven with directed and random words,
// checked against a history-of-inputs latency model, including async and edge-coincident resets.
module tb_reg1;

    logic        clk;
    logic        reset;
    logic [11:0] serial_input;
    logic [11:0] out1;
    logic [11:0] out3;

    int n_chk;
    int n_pass;

    // Words captured since the last reset release, oldest first.
    logic [11:0] hist [$];

    localparam logic [11:0] RV1 = 12'h000;
    localparam logic [11:0] RV3 = 12'hA5A;

    reg1 #(.reg_size(12), .STAGES(1)) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .serial_input  (serial_input),
        .serial_output (out1)
    );

    reg1 #(.reg_size(12), .STAGES(3), .RESET_VALUE(RV3)) u_dut3 (
        .clk           (clk),
        .reset         (reset),
        .serial_input  (serial_input),
        .serial_output (out3)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
        end
    endtask

    // A word sampled at edge N shows up after edge N+depth-1.
    function automatic logic [11:0] expv(input int depth, input logic [11:0] rv);
        if (hist.size() >= depth) return hist[hist.size() - depth];
        return rv;
    endfunction

    task automatic check_both(input string tag);
        chk({tag, "_s1"}, out1, expv(1, RV1));
        chk({tag, "_s3"}, out3, expv(3, RV3));
    endtask

    task automatic edge_step(input logic [11:0] v, input string tag);
        @(negedge clk);
        serial_input = v;
        @(posedge clk);
        if (reset) hist.push_back(v);
        #1;
        check_both(tag);
    endtask

    // Release shortly after an edge so the next capture is a clean full cycle later.
    task automatic release_rst();
        @(posedge clk);
        #5 reset = 1'b1;
        #1 check_both("rel");
    endtask

    task automatic async_rst();
        @(negedge clk);
        #3 reset = 1'b0;
        hist.delete();
        #1 check_both("arst");
        @(posedge clk);
        #1 check_both("arst_edge");
        release_rst();
    endtask

    task automatic coincident_rst();
        @(negedge clk);
        serial_input = 12'($urandom);
        #20 reset = 1'b0;
        hist.delete();
        #1 check_both("coin");
        release_rst();
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        reset        = 1'b1;
        serial_input = 12'd12;

        // Power-up reset with a running clock
        #1 reset = 1'b0;
        #1 check_both("por");
        repeat (3) begin
            @(posedge clk);
            #1 check_both("por_edge");
        end
        release_rst();
        edge_step(12'd12, "first");

        // Basic capture and mid-cycle input change
        edge_step(12'd13, "cap13");
        #10 serial_input = 12'd14;
        #2 chk("midcyc_s1", out1, 12'd13);
        edge_step(12'd14, "cap14");

        async_rst();
        edge_step(12'd13, "post_arst");

        // Multi-stage fill
        async_rst();
        edge_step(12'd7, "ms7");
        edge_step(12'd8, "ms8");
        edge_step(12'd9, "ms9");
        edge_step(12'd10, "ms10");
        edge_step(12'd11, "ms11");
        async_rst();

        // Full 12-bit range back to back
        for (int v = 0; v < 4096; v++) begin
            edge_step(12'(v), "sweep");
        end

        coincident_rst();
        edge_step(12'hFFF, "post_coin");

        // Random stream with occasional resets
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 39))
                0:       async_rst();
                1:       coincident_rst();
                default: edge_step(12'($urandom), "rnd");
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
